// File: rtl/count_seq_monitor_pkg.sv
// Shared definitions for the NBC sequence monitor: FSM encoding, default
// NBC count sequence and value<->index lookups.
package count_seq_monitor_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Default NBC count order, shared with the counter and its bench.
  localparam logic [1:0] NBC_SEQ0 = 2'b00;
  localparam logic [1:0] NBC_SEQ1 = 2'b01;
  localparam logic [1:0] NBC_SEQ2 = 2'b11;
  localparam logic [1:0] NBC_SEQ3 = 2'b10;

  function automatic logic [1:0] seq_index(input logic [1:0] v,
                                           input logic [1:0] s0,
                                           input logic [1:0] s1,
                                           input logic [1:0] s2,
                                           input logic [1:0] s3);
    logic [1:0] k;
    k = 2'd0;
    if (v == s0) k = 2'd0;
    if (v == s1) k = 2'd1;
    if (v == s2) k = 2'd2;
    if (v == s3) k = 2'd3;
    return k;
  endfunction

  function automatic logic [1:0] seq_value(input logic [1:0] k,
                                           input logic [1:0] s0,
                                           input logic [1:0] s1,
                                           input logic [1:0] s2,
                                           input logic [1:0] s3);
    logic [1:0] v;
    case (k)
      2'd0:    v = s0;
      2'd1:    v = s1;
      2'd2:    v = s2;
      default: v = s3;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/count_seq_monitor_if.sv
// Sample strobe/value from the counter side plus the monitor's status outputs.
// master drives samples, slave is the monitor.
interface count_seq_monitor_if #(
  parameter int LAP_W = 8
);
  logic             in_valid;
  logic [1:0]       in;
  logic             locked;
  logic             error;
  logic [1:0]       phase;
  logic [LAP_W-1:0] laps;
  logic [7:0]       err_count;

  modport master (
    output in_valid, in,
    input  locked, error, phase, laps, err_count
  );

  modport slave (
    input  in_valid, in,
    output locked, error, phase, laps, err_count
  );
endinterface

// File: rtl/count_seq_monitor.sv
// Checks a sampled 2-bit count against the 4-step NBC order, locks after LOCK_COUNT good steps.
// All outputs registered, one clock after the sampling edge; never stalls the source (no backpressure).
module count_seq_monitor
  import count_seq_monitor_pkg::*;
#(
  parameter logic [1:0] SEQ0       = NBC_SEQ0,
  parameter logic [1:0] SEQ1       = NBC_SEQ1,
  parameter logic [1:0] SEQ2       = NBC_SEQ2,
  parameter logic [1:0] SEQ3       = NBC_SEQ3,
  parameter int         LOCK_COUNT = 4,
  parameter int         LAP_W      = 8
) (
  input  logic           clock,
  input  logic           reset,
  count_seq_monitor_if.slave mon
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       run_q, run_d;
  logic [LAP_W-1:0] laps_q, laps_d;
  logic [7:0]       errc_q, errc_d;
  logic             error_q, error_d;
  logic             locked_q;
  logic [1:0]       phase_q;

  logic [1:0] exp_val;
  logic [1:0] seed;
  logic       hit;

  assign exp_val = seq_value(idx_q + 2'd1, SEQ0, SEQ1, SEQ2, SEQ3);
  assign seed    = seq_index(mon.in, SEQ0, SEQ1, SEQ2, SEQ3);
  // A repeated value never equals the successor, so a held count is a mismatch.
  assign hit     = (mon.in == exp_val);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    run_d   = run_q;
    laps_d  = laps_q;
    errc_d  = errc_q;
    error_d = 1'b0;
    if (mon.in_valid) begin
      case (state_q)
        HUNT: begin
          idx_d   = seed;
          run_d   = 4'd0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (hit) begin
            idx_d = idx_q + 2'd1;
            run_d = run_q + 4'd1;
            if (run_q + 4'd1 == LOCK_N) state_d = LOCKED;
          end else begin
            idx_d = seed;
            run_d = 4'd0;
          end
        end
        LOCKED: begin
          if (hit) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) laps_d = laps_q + LAP_W'(1);
          end else begin
            error_d = 1'b1;
            if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
            idx_d   = seed;
            run_d   = 4'd0;
            state_d = ACQUIRE;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= HUNT;
      idx_q    <= 2'd0;
      run_q    <= 4'd0;
      laps_q   <= '0;
      errc_q   <= 8'd0;
      error_q  <= 1'b0;
      locked_q <= 1'b0;
      phase_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      run_q    <= run_d;
      laps_q   <= laps_d;
      errc_q   <= errc_d;
      error_q  <= error_d;
      locked_q <= (state_d == LOCKED);
      phase_q  <= (state_d == LOCKED) ? idx_d : 2'd0;
    end
  end

  assign mon.locked    = locked_q;
  assign mon.error     = error_q;
  assign mon.phase     = phase_q;
  assign mon.laps      = laps_q;
  assign mon.err_count = errc_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed vector table plus hand sequences for laps, reset priority and err_count saturation.
module tb_count_seq_monitor;
  import count_seq_monitor_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  count_seq_monitor_if #(.LAP_W(8)) bus ();

  count_seq_monitor #(
    .LOCK_COUNT(4),
    .LAP_W     (8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mon  (bus)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] din;
    logic       lk;
    logic       er;
    logic [1:0] ph;
    logic [7:0] lp;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic v, input logic [1:0] d,
                     input logic lk, input logic er, input logic [1:0] ph,
                     input logic [7:0] lp, input logic [7:0] ec);
    vec_t t;
    t.rst = r; t.vld = v; t.din = d;
    t.lk = lk; t.er = er; t.ph = ph; t.lp = lp; t.ec = ec;
    vecs.push_back(t);
  endtask

  // Drive one sample, let it be clocked, then sit 1ns past the edge.
  task automatic drive(input logic r, input logic v, input logic [1:0] d);
    reset        = r;
    bus.in_valid = v;
    bus.in       = d;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic lk, input logic er,
                       input logic [1:0] ph, input logic [7:0] lp, input logic [7:0] ec);
    logic [19:0] act, want;
    act  = {bus.locked, bus.error, bus.phase, bus.laps, bus.err_count};
    want = {lk, er, ph, lp, ec};
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got locked=%0b error=%0b phase=%0d laps=%0d err_count=%0d, want locked=%0b error=%0b phase=%0d laps=%0d err_count=%0d",
               nm, bus.locked, bus.error, bus.phase, bus.laps, bus.err_count, lk, er, ph, lp, ec);
    end
  endtask

  initial begin
    logic [1:0] lap_seq[4];
    logic [1:0] d;
    lap_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in       = 2'b00;

    //  rst vld din    lk er ph   laps ec
    add(1, 0, 2'b00,  0, 0, 0,   0,   0);
    // acquire and lock on 00,01,11,10,00
    add(0, 1, 2'b00,  0, 0, 0,   0,   0);
    add(0, 1, 2'b01,  0, 0, 0,   0,   0);
    add(0, 1, 2'b11,  0, 0, 0,   0,   0);
    add(0, 1, 2'b10,  0, 0, 0,   0,   0);
    add(0, 1, 2'b00,  1, 0, 0,   0,   0);
    // one full lap while locked
    add(0, 1, 2'b01,  1, 0, 1,   0,   0);
    add(0, 1, 2'b11,  1, 0, 2,   0,   0);
    add(0, 1, 2'b10,  1, 0, 3,   0,   0);
    add(0, 1, 2'b00,  1, 0, 0,   1,   0);
    // skip to 11: error pulse, reseed at idx 2, relock after 4 steps
    add(0, 1, 2'b11,  0, 1, 0,   1,   1);
    add(0, 1, 2'b10,  0, 0, 0,   1,   1);
    add(0, 1, 2'b00,  0, 0, 0,   1,   1);
    add(0, 1, 2'b01,  0, 0, 0,   1,   1);
    add(0, 1, 2'b11,  1, 0, 2,   1,   1);
    // idle while locked: everything holds
    for (int i = 0; i < 5; i++) add(0, 0, 2'b00, 1, 0, 2, 1, 1);
    add(0, 1, 2'b10,  1, 0, 3,   1,   1);
    // held value counts as a mismatch
    add(0, 1, 2'b10,  0, 1, 0,   1,   2);
    // reset with a valid sample present; then mismatch during acquire
    add(1, 1, 2'b00,  0, 0, 0,   0,   0);
    add(0, 1, 2'b00,  0, 0, 0,   0,   0);
    add(0, 1, 2'b01,  0, 0, 0,   0,   0);
    add(0, 1, 2'b11,  0, 0, 0,   0,   0);
    add(0, 1, 2'b00,  0, 0, 0,   0,   0);
    add(0, 1, 2'b01,  0, 0, 0,   0,   0);
    add(0, 1, 2'b11,  0, 0, 0,   0,   0);
    add(0, 1, 2'b10,  0, 0, 0,   0,   0);
    add(0, 1, 2'b00,  1, 0, 0,   0,   0);

    for (int i = 0; i < vecs.size(); i++) begin
      d = vecs[i].vld ? vecs[i].din : 2'($urandom_range(0, 3));
      drive(vecs[i].rst, vecs[i].vld, d);
      check($sformatf("row%0d", i), vecs[i].lk, vecs[i].er, vecs[i].ph, vecs[i].lp, vecs[i].ec);
    end

    // three laps, then reset wins over a correct valid sample
    for (int l = 0; l < 3; l++)
      for (int s = 0; s < 4; s++) drive(1'b0, 1'b1, lap_seq[s]);
    check("three_laps", 1, 0, 0, 3, 0);
    drive(1'b1, 1'b1, 2'b01);
    check("reset_wins", 0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 2'b00);
    drive(1'b0, 1'b1, 2'b01);
    drive(1'b0, 1'b1, 2'b11);
    drive(1'b0, 1'b1, 2'b10);
    check("relock_pending", 0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 2'b00);
    check("relock", 1, 0, 0, 0, 0);

    // err_count saturation: repeated held-value mismatch then relock at idx 2
    drive(1'b0, 1'b1, 2'b01);
    drive(1'b0, 1'b1, 2'b11);
    check("pre_sat", 1, 0, 2, 0, 0);
    for (int i = 0; i < 260; i++) begin
      drive(1'b0, 1'b1, 2'b11);
      if (i == 0)   check("sat_first_pulse", 0, 1, 0, 0, 1);
      if (i == 259) check("sat_last_pulse", 0, 1, 0, 0, 255);
      drive(1'b0, 1'b1, 2'b10);
      drive(1'b0, 1'b1, 2'b00);
      drive(1'b0, 1'b1, 2'b01);
      drive(1'b0, 1'b1, 2'b11);
      if (i == 254) check("sat_255", 1, 0, 2, 0, 255);
    end
    check("sat_hold", 1, 0, 2, 0, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
Downstream consumer of the team's 2-bit NBC counter output. Checks that the sampled count follows the fixed 4-state NBC sequence and acquires lock after a run of correct transitions. Reports the phase index, completed laps and sequence errors. Used as the self-checking stage after the counter in system builds and benches.

Parameters:
SEQ0, 2'b00, expected count value at sequence index 0
SEQ1, 2'b01, expected count value at index 1
SEQ2, 2'b11, expected count value at index 2
SEQ3, 2'b10, expected count value at index 3 (SEQ0..SEQ3 must be distinct)
LOCK_COUNT, 4, consecutive correct transitions required to lock (legal 1..15)
LAP_W, 8, width of lap counter

Ports:
clock  input  1  single system clock, all state on rising edge
reset  input  1  synchronous, active-high; one clock and synchronous active-high reset, fixed
in_valid  input  1  sample strobe; in is only examined when high
in  input  2  count value from the NBC counter
locked  output  1  high while in LOCKED state
error  output  1  one-cycle pulse on sequence mismatch while LOCKED
phase  output  2  binary index (0..3) of last accepted sample when locked, else 0
laps  output  LAP_W  completed sequence laps while locked, wraps modulo 2^LAP_W
err_count  output  8  mismatch count, saturates at 255

Behaviour:
- Reset (sync, priority over everything): state=HUNT; idx=0; run=0; locked=0, error=0, phase=0, laps=0, err_count=0.
- in_valid low: no state change; error=0 that cycle; in is ignored (may be X).
- idx(v): the index k with SEQk==v. It is always defined because the SEQ values are distinct.
- FSM states: HUNT, ACQUIRE, LOCKED.
  - HUNT: on valid, idx<=idx(in), run<=0, go ACQUIRE.
  - ACQUIRE, valid and in==SEQ[idx+1 mod 4]: idx++, run++. If run+1==LOCK_COUNT, go LOCKED.
  - ACQUIRE, valid and mismatch: reseed idx<=idx(in), run<=0, stay ACQUIRE. No error pulse, err_count unchanged.
  - LOCKED, valid and expected: idx++ mod 4. If the old idx==3, laps++ (wraps).
  - LOCKED, valid and mismatch: error=1 for exactly one cycle; err_count++ (saturating); reseed idx<=idx(in), run<=0; go ACQUIRE.
- All outputs are registered. Latency is one clock from the sampling edge to the output change.
- locked rises in the cycle after the LOCK_COUNT-th correct transition is sampled.
- phase tracks idx while locked and reads 0 otherwise.
- laps and err_count are not cleared on loss of lock; only reset clears them.
- A held value (in equal to the current SEQ[idx]) counts as a mismatch.
- Reset during LOCKED with in_valid high: reset wins; next cycle is the full reset state.

Decomposition:
- Shared package holds:
  - state encoding constants (HUNT=2'd0, ACQUIRE=2'd1, LOCKED=2'd2);
  - default NBC sequence constants, shared with the counter and its bench;
  - the value-to-index lookup function.
- No sub-module. The lookup is combinational and small enough to inline via the package function.

Test Plan:
1. Reset, then valid samples 00,01,11,10,00 on consecutive clocks -> locked=1 one clock after the 5th sample; phase=0; laps=0; err_count=0.
2. Continue from 1 with 01,11,10,00 -> laps=1 after the 00 sample; phase sequence 1,3... in binary index terms 1,2,3,0; error never high.
3. Locked at phase 0, inject 11 instead of 01 -> error high for exactly one cycle; err_count=1; locked=0; then 10,00,01,11 -> locked=1 again; laps unchanged.
4. In ACQUIRE after 2 correct transitions, inject wrong value 00 after 01 -> run restarts, no error pulse; lock requires 4 further correct transitions.
5. Locked, drive in_valid=0 for 5 clocks with random in -> all outputs constant, error=0.
6. Locked with laps=3, assert reset one clock while in_valid=1 with a correct value -> next cycle locked=0, laps=0, err_count=0, phase=0; relock needs 4 transitions. Separately, force 256 lock/mismatch cycles -> err_count stays 255.
